// File: rtl/rfile_pkg.sv
// Shared types, default sizes and helpers for the multi-ported register file.
// Contents:
//   NREGS, ADDR_WIDTH, DATA_WIDTH, CNT_WIDTH - storage geometry
//   reg_addr_t, reg_data_t, busy_cnt_t, busy_vec_t - common types
//   popcount_busy()                          - number of set busy bits
package rfile_pkg;

    localparam int unsigned NREGS      = 32;
    localparam int unsigned ADDR_WIDTH = 5;   // must equal $clog2(NREGS)
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned CNT_WIDTH  = ADDR_WIDTH + 1;

    typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [DATA_WIDTH-1:0] reg_data_t;
    typedef logic [CNT_WIDTH-1:0]  busy_cnt_t;
    typedef logic [NREGS-1:0]      busy_vec_t;

    // Number of registers that currently have a pending producer.
    function automatic busy_cnt_t popcount_busy(input busy_vec_t busy);
        busy_cnt_t cnt;
        cnt = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            cnt = cnt + busy_cnt_t'(busy[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/rfile_mp_if.sv
// Register-file port bundle between dispatch/writeback (master) and the
// register file (slave).
// Signals:
//   rd_addr/rd_data/rd_busy            - NRD operand read ports
//   wr_enable/wr_addr/wr_data          - NWR writeback ports
//   rsv_enable/rsv_addr                - NRSV destination reservation ports
//   busy_count                         - registered number of busy registers
interface rfile_mp_if #(
    parameter int unsigned NRD  = 4,
    parameter int unsigned NWR  = 2,
    parameter int unsigned NRSV = 2
) ();
    import rfile_pkg::*;

    reg_addr_t [NRD-1:0]  rd_addr;
    reg_data_t [NRD-1:0]  rd_data;
    logic      [NRD-1:0]  rd_busy;
    logic      [NWR-1:0]  wr_enable;
    reg_addr_t [NWR-1:0]  wr_addr;
    reg_data_t [NWR-1:0]  wr_data;
    logic      [NRSV-1:0] rsv_enable;
    reg_addr_t [NRSV-1:0] rsv_addr;
    busy_cnt_t            busy_count;

    modport master (
        output rd_addr, wr_enable, wr_addr, wr_data, rsv_enable, rsv_addr,
        input  rd_data, rd_busy, busy_count
    );

    modport slave (
        input  rd_addr, wr_enable, wr_addr, wr_data, rsv_enable, rsv_addr,
        output rd_data, rd_busy, busy_count
    );

endinterface

// File: rtl/rfile_scoreboard.sv
// Per-register busy scoreboard: reservations set a bit, writebacks clear it,
// and a reservation wins over a same-cycle writeback (it is the newer producer).
// Optional: RFILE_BYPASS_EN makes rd_busy reflect same-cycle writebacks.
// Ports:
//   clock, reset_n      - clock, async active-low reset
//   rd_addr_i           - read addresses whose busy bit is reported
//   wr_enable_i/addr_i  - writeback ports (clear)
//   rsv_enable_i/addr_i - reservation ports (set)
//   rd_busy_o           - busy bit per read port (combinational from state)
//   busy_count_o        - registered popcount of the busy vector
module rfile_scoreboard
    import rfile_pkg::*;
#(
    parameter int unsigned NRD      = 4,
    parameter int unsigned NWR      = 2,
    parameter int unsigned NRSV     = 2,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  reg_addr_t [NRD-1:0]  rd_addr_i,
    input  logic      [NWR-1:0]  wr_enable_i,
    input  reg_addr_t [NWR-1:0]  wr_addr_i,
    input  logic      [NRSV-1:0] rsv_enable_i,
    input  reg_addr_t [NRSV-1:0] rsv_addr_i,
    output logic      [NRD-1:0]  rd_busy_o,
    output busy_cnt_t            busy_count_o
);

    busy_vec_t busy_q;
    busy_vec_t busy_d;
    busy_vec_t set_vec;
    busy_vec_t clr_vec;
    busy_vec_t busy_view;
    busy_cnt_t count_q;

    // Decode reservations and writebacks into per-register set/clear masks.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        for (int unsigned r = 0; r < NREGS; r++) begin
            for (int unsigned k = 0; k < NRSV; k++) begin
                if (rsv_enable_i[k] && (rsv_addr_i[k] == reg_addr_t'(r))) begin
                    set_vec[r] = 1'b1;
                end
            end
            for (int unsigned p = 0; p < NWR; p++) begin
                if (wr_enable_i[p] && (wr_addr_i[p] == reg_addr_t'(r))) begin
                    clr_vec[r] = 1'b1;
                end
            end
        end
        if (ZERO_REG) begin
            set_vec[0] = 1'b0;
        end
    end

    assign busy_d = set_vec | (busy_q & ~clr_vec);

    // Busy state and its count update on the same edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= popcount_busy(busy_d);
        end
    end

`ifdef RFILE_BYPASS_EN
    // A register being written this cycle reads as busy only if it is also re-reserved.
    assign busy_view = reset_n ? ((busy_q & ~clr_vec) | (set_vec & clr_vec)) : '0;
`else
    assign busy_view = busy_q;
`endif

    // Busy read mux; addresses outside the file read as not busy.
    always_comb begin
        rd_busy_o = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                if (rd_addr_i[i] == reg_addr_t'(r)) begin
                    rd_busy_o[i] = busy_view[r];
                end
            end
        end
    end

    assign busy_count_o = count_q;

endmodule

// File: rtl/rfile_mp.sv
// Multi-ported register file with busy scoreboard for the superscalar core.
// NRD combinational read ports, NWR writeback ports (highest index wins on
// collision), NRSV reservation ports. ZERO_REG=1 hardwires register 0 to zero.
// Optional: define RFILE_BYPASS_EN for same-cycle write-to-read forwarding.
// Ports:
//   clock   - core clock, all state on posedge
//   reset_n - asynchronous active-low reset
//   bus     - rfile_mp_if.slave: read, write, reserve ports and busy_count
module rfile_mp
    import rfile_pkg::*;
#(
    parameter int unsigned NRD      = 4,
    parameter int unsigned NWR      = 2,
    parameter int unsigned NRSV     = 2,
    parameter bit          ZERO_REG = 1'b1
) (
    input logic       clock,
    input logic       reset_n,
    rfile_mp_if.slave bus
);

    reg_data_t           regs_q [NREGS];
    reg_data_t           regs_d [NREGS];
    reg_data_t [NRD-1:0] rd_data_c;

    // Next register contents; ascending port loop gives the highest port priority.
    always_comb begin
        regs_d = regs_q;
        for (int unsigned r = 0; r < NREGS; r++) begin
            for (int unsigned p = 0; p < NWR; p++) begin
                if (bus.wr_enable[p] && (bus.wr_addr[p] == reg_addr_t'(r))) begin
                    regs_d[r] = bus.wr_data[p];
                end
            end
        end
        if (ZERO_REG) begin
            regs_d[0] = '0;
        end
    end

    // Data array.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read muxes. With forwarding, the next-state value already carries the
    // write priority and register-0 masking, so it doubles as the bypass source.
    always_comb begin
        rd_data_c = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                if (bus.rd_addr[i] == reg_addr_t'(r)) begin
`ifdef RFILE_BYPASS_EN
                    rd_data_c[i] = reset_n ? regs_d[r] : regs_q[r];
`else
                    rd_data_c[i] = regs_q[r];
`endif
                end
            end
        end
    end

    assign bus.rd_data = rd_data_c;

    rfile_scoreboard #(
        .NRD      (NRD),
        .NWR      (NWR),
        .NRSV     (NRSV),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clock        (clock),
        .reset_n      (reset_n),
        .rd_addr_i    (bus.rd_addr),
        .wr_enable_i  (bus.wr_enable),
        .wr_addr_i    (bus.wr_addr),
        .rsv_enable_i (bus.rsv_enable),
        .rsv_addr_i   (bus.rsv_addr),
        .rd_busy_o    (bus.rd_busy),
        .busy_count_o (bus.busy_count)
    );

endmodule

// File: tb/tb_rfile_mp.sv
// Directed bench for rfile_mp. Stimulus pushes expected read/busy/count values
// tagged with the cycle they apply to; a negedge monitor pops and compares.
module tb_rfile_mp;
    import rfile_pkg::*;

    localparam int unsigned NRD  = 4;
    localparam int unsigned NWR  = 2;
    localparam int unsigned NRSV = 2;
    localparam int K_DATA = 0;
    localparam int K_BUSY = 1;
    localparam int K_CNT  = 2;
`ifdef RFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        int          cyc;
        int          kind;
        logic [1:0]  port;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];

    rfile_mp_if #(.NRD(NRD), .NWR(NWR), .NRSV(NRSV)) bus ();

    rfile_mp #(
        .NRD      (NRD),
        .NWR      (NWR),
        .NRSV     (NRSV),
        .ZERO_REG (1'b1)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: compare every expectation due in this cycle at the falling edge.
    exp_t        m_e;
    logic [31:0] m_act;
    always @(negedge clock) begin
        while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            m_e = exp_q.pop_front();
            case (m_e.kind)
                K_DATA:  m_act = bus.rd_data[m_e.port];
                K_BUSY:  m_act = 32'(bus.rd_busy[m_e.port]);
                default: m_act = 32'(bus.busy_count);
            endcase
            checks++;
            if (m_e.cyc != cyc || m_act !== m_e.val) begin
                failures++;
                $display("FAIL %s: cycle %0d got 0x%0h expected 0x%0h",
                         m_e.name, cyc, m_act, m_e.val);
            end
        end
    end

    task automatic chk(input int kind, input logic [1:0] port,
                       input logic [31:0] val, input string name);
        exp_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.port = port;
        e.val  = val;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        bus.wr_enable  = '0;
        bus.rsv_enable = '0;
    endtask

    task automatic wr(input logic p, input reg_addr_t a, input reg_data_t d);
        bus.wr_enable[p] = 1'b1;
        bus.wr_addr[p]   = a;
        bus.wr_data[p]   = d;
    endtask

    task automatic rsv(input logic p, input reg_addr_t a);
        bus.rsv_enable[p] = 1'b1;
        bus.rsv_addr[p]   = a;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        reset_n        = 1'b0;
        bus.rd_addr    = '0;
        bus.wr_enable  = '0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.rsv_enable = '0;
        bus.rsv_addr   = '0;

        tick();
        chk(K_DATA, 2'd0, 32'h0, "reset_data");
        chk(K_BUSY, 2'd0, 32'h0, "reset_busy");
        chk(K_CNT,  2'd0, 32'h0, "reset_count");
        tick();
        reset_n = 1'b1;

        // Build reg5=0xDEAD, busy[5]=1, then reset asynchronously mid-cycle.
        wr(1'b0, 5'd5, 32'hDEAD);
        tick();
        bus.rd_addr[0] = 5'd5;
        rsv(1'b0, 5'd5);
        chk(K_DATA, 2'd0, 32'hDEAD, "t1_data_pre");
        chk(K_BUSY, 2'd0, 32'h0,    "t1_busy_pre");
        chk(K_CNT,  2'd0, 32'h0,    "t1_cnt_pre");
        tick();
        chk(K_DATA, 2'd0, 32'hDEAD, "t1_data_set");
        chk(K_BUSY, 2'd0, 32'h1,    "t1_busy_set");
        chk(K_CNT,  2'd0, 32'h1,    "t1_cnt_set");
        tick();
        reset_n = 1'b0;
        wr(1'b0, 5'd6, 32'h1234);
        rsv(1'b0, 5'd6);
        bus.rd_addr[1] = 5'd6;
        chk(K_DATA, 2'd0, 32'h0, "t1_async_data");
        chk(K_BUSY, 2'd0, 32'h0, "t1_async_busy");
        chk(K_CNT,  2'd0, 32'h0, "t1_async_cnt");
        chk(K_DATA, 2'd1, 32'h0, "t1_async_wr_data");
        chk(K_BUSY, 2'd1, 32'h0, "t1_async_rsv_busy");
        tick();
        reset_n = 1'b1;
        chk(K_DATA, 2'd0, 32'h0, "t1_post_data5");
        chk(K_DATA, 2'd1, 32'h0, "t1_post_data6");
        chk(K_BUSY, 2'd1, 32'h0, "t1_post_busy6");
        chk(K_CNT,  2'd0, 32'h0, "t1_post_cnt");
        tick();

        // Two ports write reg 7: port 1 wins.
        bus.rd_addr[1] = 5'd7;
        wr(1'b0, 5'd7, 32'h1111);
        wr(1'b1, 5'd7, 32'h2222);
        chk(K_DATA, 2'd1, BYP ? 32'h2222 : 32'h0, "t2_same_cycle");
        tick();
        chk(K_DATA, 2'd1, 32'h2222, "t2_port1_wins");
        tick();

        // Reserve reg 9, write back three cycles later.
        bus.rd_addr[2] = 5'd9;
        rsv(1'b0, 5'd9);
        chk(K_BUSY, 2'd2, 32'h0, "t3_busy_c0");
        chk(K_CNT,  2'd0, 32'h0, "t3_cnt_c0");
        tick();
        chk(K_BUSY, 2'd2, 32'h1, "t3_busy_c1");
        chk(K_CNT,  2'd0, 32'h1, "t3_cnt_c1");
        tick();
        chk(K_BUSY, 2'd2, 32'h1, "t3_busy_c2");
        tick();
        wr(1'b0, 5'd9, 32'hABCD);
        chk(K_BUSY, 2'd2, BYP ? 32'h0 : 32'h1,       "t3_busy_c3");
        chk(K_DATA, 2'd2, BYP ? 32'hABCD : 32'h0,    "t3_data_c3");
        chk(K_CNT,  2'd0, 32'h1,                     "t3_cnt_c3");
        tick();
        chk(K_BUSY, 2'd2, 32'h0,    "t3_busy_c4");
        chk(K_DATA, 2'd2, 32'hABCD, "t3_data_c4");
        chk(K_CNT,  2'd0, 32'h0,    "t3_cnt_c4");
        tick();

        // Reserve and write reg 9 together: reservation wins.
        rsv(1'b0, 5'd9);
        wr(1'b1, 5'd9, 32'h5);
        chk(K_BUSY, 2'd2, BYP ? 32'h1 : 32'h0,    "t4_busy_same");
        chk(K_DATA, 2'd2, BYP ? 32'h5 : 32'hABCD, "t4_data_same");
        chk(K_CNT,  2'd0, 32'h0,                  "t4_cnt_same");
        tick();
        chk(K_BUSY, 2'd2, 32'h1, "t4_busy_after");
        chk(K_DATA, 2'd2, 32'h5, "t4_data_after");
        chk(K_CNT,  2'd0, 32'h1, "t4_cnt_after");
        tick();

        // Register 0 ignores writes and reservations.
        bus.rd_addr[3] = 5'd0;
        wr(1'b0, 5'd0, 32'hFFFF);
        rsv(1'b1, 5'd0);
        chk(K_DATA, 2'd3, 32'h0, "t5_data_same");
        chk(K_BUSY, 2'd3, 32'h0, "t5_busy_same");
        tick();
        chk(K_DATA, 2'd3, 32'h0, "t5_data_after");
        chk(K_BUSY, 2'd3, 32'h0, "t5_busy_after");
        chk(K_CNT,  2'd0, 32'h1, "t5_cnt_after");
        tick();

        // Duplicate reservation of reg 12 counts once.
        bus.rd_addr[3] = 5'd12;
        rsv(1'b0, 5'd12);
        rsv(1'b1, 5'd12);
        chk(K_BUSY, 2'd3, 32'h0, "dup_busy_same");
        tick();
        chk(K_BUSY, 2'd3, 32'h1, "dup_busy_after");
        chk(K_CNT,  2'd0, 32'h2, "dup_cnt_after");
        tick();

        // Write back regs 9 and 12 on both ports at once.
        wr(1'b0, 5'd9,  32'h1);
        wr(1'b1, 5'd12, 32'h2);
        chk(K_BUSY, 2'd2, BYP ? 32'h0 : 32'h1, "clr_busy9_same");
        chk(K_BUSY, 2'd3, BYP ? 32'h0 : 32'h1, "clr_busy12_same");
        chk(K_DATA, 2'd3, BYP ? 32'h2 : 32'h0, "clr_data12_same");
        chk(K_CNT,  2'd0, 32'h2,               "clr_cnt_same");
        tick();
        chk(K_BUSY, 2'd2, 32'h0, "clr_busy9_after");
        chk(K_BUSY, 2'd3, 32'h0, "clr_busy12_after");
        chk(K_DATA, 2'd2, 32'h1, "clr_data9_after");
        chk(K_DATA, 2'd3, 32'h2, "clr_data12_after");
        chk(K_CNT,  2'd0, 32'h0, "clr_cnt_after");
        tick();

        // Write-to-read visibility.
        bus.rd_addr[0] = 5'd3;
        wr(1'b0, 5'd3, 32'h77);
        chk(K_DATA, 2'd0, BYP ? 32'h77 : 32'h0, "t6_data_same");
        tick();
        chk(K_DATA, 2'd0, 32'h77, "t6_data_next");
        tick();
        tick();

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL leftover: %0d expectations unsampled, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
